vector_seq_ctrl: RTL and testbench

Sequences the 6502 reset, NMI, IRQ and BRK entry sequences. It pushes PC and P onto the stack, fetches the 16-bit vector, and loads PC. It drives the PC and SP register write ports and owns the memory bus while busy. It sits beside the instruction decoder, which hands over control at instruction boundaries.

---
 rtl/vector_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_vector_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_seq_ctrl.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: stack pushes, vector fetch, PC load.
// Optional VEC_CLR_D_EN: pulse clr_d alongside set_i in LOAD_PC (65C02).
module vector_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-DATA_WIDTH-1:0] STACK_PAGE = 8'h01,
  parameter int RST_DUMMY = 3,
  parameter logic [ADDR_WIDTH-1:0] VEC_NMI = 16'hFFFA,
  parameter logic [ADDR_WIDTH-1:0] VEC_RST = 16'hFFFC,
  parameter logic [ADDR_WIDTH-1:0] VEC_IRQ = 16'hFFFE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  nmi_n,
  input  logic                  irq_n,
  input  logic                  brk_req,
  input  logic                  inst_done,
  input  logic                  i_flag,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] p,
  input  logic [DATA_WIDTH-1:0] sp,
  input  logic [DATA_WIDTH-1:0] mem_din,
  input  logic                  mem_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  pc_we,
  output logic [ADDR_WIDTH-1:0] pc_din,
  output logic                  sp_we,
  output logic [DATA_WIDTH-1:0] sp_din,
  output logic                  set_i,
  output logic                  clr_d,
  output logic                  busy
);

  localparam int CW = (RST_DUMMY > 1) ? $clog2(RST_DUMMY) : 1;
  localparam logic [CW-1:0] LAST = CW'(RST_DUMMY - 1);

  typedef enum logic [3:0] {
    S_RST_HOLD,
    S_RST_DUMMY,
    S_IDLE,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_P,
    S_FETCH_LO,
    S_FETCH_HI,
    S_LOAD_PC
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_nmi_prev;
  logic                    r_nmi_pend;
  logic [CW-1:0]           r_cnt;
  logic                    r_brk;
  logic [ADDR_WIDTH-1:0]   r_vec;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic [DATA_WIDTH-1:0]   r_hi;

  logic                    w_nmi_fall;
  logic                    w_take_nmi;
  logic                    w_brk_next;
  logic                    w_vec_ld;
  logic [ADDR_WIDTH-1:0]   w_vec_val;
  logic [ADDR_WIDTH-1:0]   w_stack;
  logic [DATA_WIDTH-1:0]   w_sp_dec;
  logic [DATA_WIDTH-1:0]   w_p_push;

  assign w_nmi_fall = r_nmi_prev & ~nmi_n;
  assign w_stack    = {STACK_PAGE, sp};
  assign w_sp_dec   = sp - DATA_WIDTH'(1);

  // Pushed P: bit5 forced high, bit4 (B) marks a software BRK.
  always_comb begin
    w_p_push    = p;
    w_p_push[5] = 1'b1;
    w_p_push[4] = r_brk;
  end

  always_comb begin
    w_next     = r_state;
    w_take_nmi = 1'b0;
    w_brk_next = r_brk;
    w_vec_ld   = 1'b0;
    w_vec_val  = VEC_IRQ;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_dout   = '0;
    pc_we      = 1'b0;
    pc_din     = '0;
    sp_we      = 1'b0;
    sp_din     = '0;
    set_i      = 1'b0;
    clr_d      = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_RST_HOLD: begin
        w_next = S_RST_DUMMY;
      end
      S_RST_DUMMY: begin
        mem_re   = 1'b1;
        mem_addr = w_stack;
        if (mem_rdy) begin
          sp_we  = 1'b1;
          sp_din = w_sp_dec;
          if (r_cnt == LAST) begin
            w_next    = S_FETCH_LO;
            w_vec_ld  = 1'b1;
            w_vec_val = VEC_RST;
          end
        end
      end
      S_IDLE: begin
        busy = 1'b0;
        if (inst_done) begin
          if (r_nmi_pend) begin
            w_next     = S_PUSH_PCH;
            w_brk_next = 1'b0;
          end else if (brk_req) begin
            w_next     = S_PUSH_PCH;
            w_brk_next = 1'b1;
          end else if (!irq_n && !i_flag) begin
            w_next     = S_PUSH_PCH;
            w_brk_next = 1'b0;
          end
        end
      end
      S_PUSH_PCH: begin
        mem_we   = 1'b1;
        mem_addr = w_stack;
        mem_dout = pc[ADDR_WIDTH-1:DATA_WIDTH];
        if (mem_rdy) begin
          sp_we  = 1'b1;
          sp_din = w_sp_dec;
          w_next = S_PUSH_PCL;
        end
      end
      S_PUSH_PCL: begin
        mem_we   = 1'b1;
        mem_addr = w_stack;
        mem_dout = pc[DATA_WIDTH-1:0];
        if (mem_rdy) begin
          sp_we  = 1'b1;
          sp_din = w_sp_dec;
          w_next = S_PUSH_P;
        end
      end
      S_PUSH_P: begin
        mem_we   = 1'b1;
        mem_addr = w_stack;
        mem_dout = w_p_push;
        if (mem_rdy) begin
          sp_we    = 1'b1;
          sp_din   = w_sp_dec;
          w_next   = S_FETCH_LO;
          w_vec_ld = 1'b1;
          // A pending NMI hijacks BRK/IRQ at the last moment.
          if (r_nmi_pend) begin
            w_vec_val  = VEC_NMI;
            w_take_nmi = 1'b1;
          end
        end
      end
      S_FETCH_LO: begin
        mem_re   = 1'b1;
        mem_addr = r_vec;
        if (mem_rdy) w_next = S_FETCH_HI;
      end
      S_FETCH_HI: begin
        mem_re   = 1'b1;
        mem_addr = r_vec + ADDR_WIDTH'(1);
        if (mem_rdy) w_next = S_LOAD_PC;
      end
      S_LOAD_PC: begin
        pc_we  = 1'b1;
        pc_din = {r_hi, r_lo};
        set_i  = 1'b1;
`ifdef VEC_CLR_D_EN
        clr_d  = 1'b1;
`endif
        w_next = S_IDLE;
      end
      default: w_next = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RST_HOLD;
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_cnt      <= '0;
      r_brk      <= 1'b0;
      r_vec      <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
    end else begin
      r_state    <= w_next;
      r_nmi_prev <= nmi_n;
      r_brk      <= w_brk_next;
      // A new edge wins over a same-cycle clear.
      if (w_nmi_fall)      r_nmi_pend <= 1'b1;
      else if (w_take_nmi) r_nmi_pend <= 1'b0;
      if (r_state == S_RST_DUMMY && mem_rdy)
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      if (w_vec_ld) r_vec <= w_vec_val;
      if (r_state == S_FETCH_LO && mem_rdy) r_lo <= mem_din;
      if (r_state == S_FETCH_HI && mem_rdy) r_hi <= mem_din;
    end
  end

endmodule

// File: tb/tb_vector_seq_ctrl.sv
// Directed bench for vector_seq_ctrl: reset, IRQ, BRK, NMI, stalls, SP wrap.
module tb_vector_seq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic        inst_done;
  logic        i_flag;
  logic [15:0] pc;
  logic [7:0]  p;
  logic [7:0]  sp;
  logic [7:0]  mem_din;
  logic        mem_rdy;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        pc_we;
  logic [15:0] pc_din;
  logic        sp_we;
  logic [7:0]  sp_din;
  logic        set_i;
  logic        clr_d;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic        ld;
  logic [15:0] ld_pc;
  logic [7:0]  ld_sp;

  logic [15:0] wa [8];
  logic [7:0]  wd [8];
  logic [15:0] ra [8];
  logic [7:0]  sd [8];
  int          nw, nr, ns, nboth, pcc;
  logic [15:0] pcd;
  logic        si, cd, busy_after, done;
  logic        exp_cd;

  vector_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .nmi_n(nmi_n), .irq_n(irq_n),
    .brk_req(brk_req), .inst_done(inst_done), .i_flag(i_flag),
    .pc(pc), .p(p), .sp(sp), .mem_din(mem_din), .mem_rdy(mem_rdy),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_dout(mem_dout), .pc_we(pc_we), .pc_din(pc_din),
    .sp_we(sp_we), .sp_din(sp_din), .set_i(set_i), .clr_d(clr_d),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (mem_addr)
      16'hFFFA: mem_din = 8'h00;
      16'hFFFB: mem_din = 8'h90;
      16'hFFFC: mem_din = 8'h34;
      16'hFFFD: mem_din = 8'h12;
      16'hFFFE: mem_din = 8'h00;
      16'hFFFF: mem_din = 8'h80;
      default:  mem_din = 8'hA5;
    endcase
  end

  // PC/SP register file the controller writes into.
  always @(posedge clk) begin
    if (ld) begin
      pc <= ld_pc;
      sp <= ld_sp;
    end else begin
      if (pc_we) pc <= pc_din;
      if (sp_we) sp <= sp_din;
    end
  end

  task automatic set_regs(input logic [15:0] v_pc, input logic [7:0] v_sp);
    ld_pc = v_pc;
    ld_sp = v_sp;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic capture(input int maxc, input int nmi_cyc);
    nw = 0; nr = 0; ns = 0; nboth = 0; pcc = 0; done = 1'b0;
    pcd = '0; si = 1'b0; cd = 1'b0; busy_after = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wa[k] = '0; wd[k] = '0; ra[k] = '0; sd[k] = '0;
    end
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk); #1;
      if (mem_re && mem_we) nboth++;
      if (mem_we && mem_rdy && nw < 8) begin
        wa[nw] = mem_addr; wd[nw] = mem_dout; nw++;
      end
      if (mem_re && mem_rdy && nr < 8) begin
        ra[nr] = mem_addr; nr++;
      end
      if (sp_we && ns < 8) begin
        sd[ns] = sp_din; ns++;
      end
      if (c == nmi_cyc) nmi_n = 1'b0;
      if (pc_we) begin
        pcd = pc_din; pcc = c; si = set_i; cd = clr_d;
        @(negedge clk); #1;
        busy_after = busy;
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    inst_done = 1'b1;
    @(posedge clk); #1;
    inst_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] ea [3];
    logic [7:0]  es [3];
    ea = '{16'h01FD, 16'h01FC, 16'h01FB};
    es = '{8'hFC, 8'hFB, 8'hFA};
    set_regs(16'h0000, 8'hFD);
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got %b want 1", busy); end
    n_cmp++; if ({mem_re, mem_we, pc_we, sp_we} !== 4'b0) begin n_bad++; $display("FAIL rst_strobes got %b want 0000", {mem_re, mem_we, pc_we, sp_we}); end
    n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0000", mem_addr); end
    reset_n = 1'b1;
    capture(30, -1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rst_timeout got %b want 1", done); end
    n_cmp++; if (ns !== 3) begin n_bad++; $display("FAIL rst_nsp got %0d want 3", ns); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ra[i] !== ea[i]) begin n_bad++; $display("FAIL rst_raddr%0d got %h want %h", i, ra[i], ea[i]); end
      n_cmp++; if (sd[i] !== es[i]) begin n_bad++; $display("FAIL rst_spdin%0d got %h want %h", i, sd[i], es[i]); end
    end
    n_cmp++; if (nw !== 0) begin n_bad++; $display("FAIL rst_writes got %0d want 0", nw); end
    n_cmp++; if (ra[3] !== 16'hFFFC || ra[4] !== 16'hFFFD) begin n_bad++; $display("FAIL rst_vec got %h/%h want FFFC/FFFD", ra[3], ra[4]); end
    n_cmp++; if (pcd !== 16'h1234) begin n_bad++; $display("FAIL rst_pc got %h want 1234", pcd); end
    n_cmp++; if (cd !== exp_cd) begin n_bad++; $display("FAIL rst_clrd got %b want %b", cd, exp_cd); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL rst_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_irq();
    logic [15:0] ea [3];
    logic [7:0]  ed [3];
    logic [7:0]  es [3];
    ea = '{16'h01FF, 16'h01FE, 16'h01FD};
    ed = '{8'hC1, 8'h23, 8'h20};
    es = '{8'hFE, 8'hFD, 8'hFC};
    set_regs(16'hC123, 8'hFF);
    p = 8'h00; i_flag = 1'b0; irq_n = 1'b0;
    pulse_done();
    irq_n = 1'b1;
    capture(20, -1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL irq_timeout got %b want 1", done); end
    n_cmp++; if (nw !== 3) begin n_bad++; $display("FAIL irq_nw got %0d want 3", nw); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin n_bad++; $display("FAIL irq_w%0d got %h=%h want %h=%h", i, wa[i], wd[i], ea[i], ed[i]); end
      n_cmp++; if (sd[i] !== es[i]) begin n_bad++; $display("FAIL irq_sp%0d got %h want %h", i, sd[i], es[i]); end
    end
    n_cmp++; if (nr !== 2 || ra[0] !== 16'hFFFE || ra[1] !== 16'hFFFF) begin n_bad++; $display("FAIL irq_vec got %0d %h/%h want 2 FFFE/FFFF", nr, ra[0], ra[1]); end
    n_cmp++; if (pcd !== 16'h8000) begin n_bad++; $display("FAIL irq_pc got %h want 8000", pcd); end
    n_cmp++; if (si !== 1'b1) begin n_bad++; $display("FAIL irq_seti got %b want 1", si); end
    n_cmp++; if (cd !== exp_cd) begin n_bad++; $display("FAIL irq_clrd got %b want %b", cd, exp_cd); end
    n_cmp++; if (pcc !== 6) begin n_bad++; $display("FAIL irq_latency got %0d want 6", pcc); end
    n_cmp++; if (nboth !== 0) begin n_bad++; $display("FAIL irq_re_we got %0d want 0", nboth); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL irq_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_brk();
    set_regs(16'h4567, 8'hFF);
    p = 8'hC3; i_flag = 1'b1; irq_n = 1'b0; brk_req = 1'b1;
    pulse_done();
    brk_req = 1'b0;
    capture(20, -1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL brk_timeout got %b want 1", done); end
    n_cmp++; if (wd[0] !== 8'h45 || wd[1] !== 8'h67) begin n_bad++; $display("FAIL brk_pcpush got %h%h want 4567", wd[0], wd[1]); end
    n_cmp++; if (wd[2] !== 8'hF3) begin n_bad++; $display("FAIL brk_ppush got %h want F3", wd[2]); end
    n_cmp++; if (pcd !== 16'h8000) begin n_bad++; $display("FAIL brk_pc got %h want 8000", pcd); end
    pulse_done();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (busy !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL irq_masked%0d got busy=%b we=%b want 0/0", i, busy, mem_we); end
    end
    i_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL irq_no_done%0d got busy=%b want 0", i, busy); end
    end
    irq_n = 1'b1;
    p = 8'h00;
  endtask

  task automatic test_nmi_hijack();
    set_regs(16'hC123, 8'hFF);
    p = 8'h00; i_flag = 1'b0; irq_n = 1'b0;
    pulse_done();
    irq_n = 1'b1;
    capture(20, 2);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL hij_timeout got %b want 1", done); end
    n_cmp++; if (wd[2] !== 8'h20) begin n_bad++; $display("FAIL hij_ppush got %h want 20", wd[2]); end
    n_cmp++; if (ra[0] !== 16'hFFFA || ra[1] !== 16'hFFFB) begin n_bad++; $display("FAIL hij_vec got %h/%h want FFFA/FFFB", ra[0], ra[1]); end
    n_cmp++; if (pcd !== 16'h9000) begin n_bad++; $display("FAIL hij_pc got %h want 9000", pcd); end
    pulse_done();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hij_no_repeat%0d got busy=%b want 0", i, busy); end
    end
    nmi_n = 1'b1;
  endtask

  task automatic test_nmi_idle();
    set_regs(16'h2233, 8'hFF);
    p = 8'h08;
    nmi_n = 1'b0;
    @(posedge clk); #1;
    pulse_done();
    capture(20, -1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL nmi_timeout got %b want 1", done); end
    n_cmp++; if (wd[0] !== 8'h22 || wd[1] !== 8'h33 || wd[2] !== 8'h28) begin n_bad++; $display("FAIL nmi_push got %h %h %h want 22 33 28", wd[0], wd[1], wd[2]); end
    n_cmp++; if (pcd !== 16'h9000) begin n_bad++; $display("FAIL nmi_pc got %h want 9000", pcd); end
    nmi_n = 1'b1;
    p = 8'h00;
  endtask

  task automatic test_stall_abort();
    logic pcw_seen;
    set_regs(16'hC123, 8'hFF);
    p = 8'h00; i_flag = 1'b0; irq_n = 1'b0; mem_rdy = 1'b0;
    pulse_done();
    irq_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 16'h01FF || mem_dout !== 8'hC1) begin n_bad++; $display("FAIL stall_hold%0d got we=%b %h=%h want 1 01FF=C1", i, mem_we, mem_addr, mem_dout); end
      n_cmp++; if (sp_we !== 1'b0) begin n_bad++; $display("FAIL stall_spwe%0d got %b want 0", i, sp_we); end
    end
    mem_rdy = 1'b1;
    #1;
    n_cmp++; if (sp_we !== 1'b1 || sp_din !== 8'hFE) begin n_bad++; $display("FAIL stall_release got %b/%h want 1/FE", sp_we, sp_din); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
    end
    n_cmp++; if (mem_re !== 1'b1 || mem_addr !== 16'hFFFF) begin n_bad++; $display("FAIL abort_at_fhi got re=%b %h want 1 FFFF", mem_re, mem_addr); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1 || mem_re !== 1'b0 || pc_we !== 1'b0) begin n_bad++; $display("FAIL abort_state got busy=%b re=%b pcwe=%b want 1 0 0", busy, mem_re, pc_we); end
    pcw_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (pc_we) pcw_seen = 1'b1;
    end
    n_cmp++; if (pcw_seen !== 1'b0) begin n_bad++; $display("FAIL abort_pcwe got %b want 0", pcw_seen); end
    set_regs(16'h0000, 8'hFD);
    reset_n = 1'b1;
    capture(30, -1);
    n_cmp++; if (done !== 1'b1 || pcd !== 16'h1234) begin n_bad++; $display("FAIL abort_reboot got %b %h want 1 1234", done, pcd); end
  endtask

  task automatic test_sp_wrap();
    logic [15:0] ea [3];
    logic [7:0]  es [3];
    ea = '{16'h0100, 16'h01FF, 16'h01FE};
    es = '{8'hFF, 8'hFE, 8'hFD};
    set_regs(16'hC123, 8'h00);
    p = 8'h00; i_flag = 1'b0; irq_n = 1'b0;
    pulse_done();
    irq_n = 1'b1;
    capture(20, -1);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wrap_timeout got %b want 1", done); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (wa[i] !== ea[i]) begin n_bad++; $display("FAIL wrap_addr%0d got %h want %h", i, wa[i], ea[i]); end
      n_cmp++; if (sd[i] !== es[i]) begin n_bad++; $display("FAIL wrap_sp%0d got %h want %h", i, sd[i], es[i]); end
    end
  endtask

  initial begin
`ifdef VEC_CLR_D_EN
    exp_cd = 1'b1;
`else
    exp_cd = 1'b0;
`endif
    reset_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; brk_req = 1'b0;
    inst_done = 1'b0; i_flag = 1'b0; p = 8'h00; mem_rdy = 1'b1;
    ld = 1'b0; ld_pc = '0; ld_sp = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_irq();
    test_brk();
    test_nmi_hijack();
    test_nmi_idle();
    test_stall_abort();
    test_sp_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
